// File: rtl/jtkunio_romrq_pkg.sv
// rtl/jtkunio_romrq_pkg.sv - shared constants for the layer ROM request responder
package jtkunio_romrq_pkg;

  localparam int DEFAULT_SDRAMW = 22;

  // Fetch state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // SDRAM word-address base of each graphics layer's ROM region
  localparam logic [DEFAULT_SDRAMW-1:0] CHAR_OFFSET = 22'h00_0000;
  localparam logic [DEFAULT_SDRAMW-1:0] SCR_OFFSET  = 22'h04_0000;
  localparam logic [DEFAULT_SDRAMW-1:0] OBJ_OFFSET  = 22'h08_0000;

endpackage

// File: rtl/jtkunio_romrq_tags.sv
// rtl/jtkunio_romrq_tags.sv - two-entry tag/data store with LRU replacement
module jtkunio_romrq_tags #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lookup_en,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [31:0]   hit_data,
  input  logic          fill_en,
  input  logic [AW-1:0] fill_tag,
  input  logic [31:0]   fill_data
);

  logic [1:0]         valid_q, valid_d;
  logic [1:0][AW-1:0] tag_q, tag_d;
  logic [1:0][31:0]   data_q, data_d;
  logic               lru_q, lru_d;
  logic               match0, match1;

  // Lookup on pre-fill contents; entry 0 has priority if both were to match
  always_comb begin
    match0   = valid_q[0] && (tag_q[0] == lookup_addr);
    match1   = valid_q[1] && (tag_q[1] == lookup_addr);
    hit      = match0 || match1;
    hit_data = match0 ? data_q[0] : data_q[1];
  end

  // Next-state: a hit points LRU at the other entry; a fill overrides that
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    lru_d   = lru_q;
    if (lookup_en && hit) begin
      lru_d = match0;
    end
    if (fill_en) begin
      valid_d[lru_q] = 1'b1;
      tag_d[lru_q]   = fill_tag;
      data_d[lru_q]  = fill_data;
      lru_d          = ~lru_q;
    end
  end

  // Store registers; reset invalidates both entries
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      lru_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      lru_q   <= lru_d;
    end
  end

endmodule

// File: rtl/jtkunio_romrq.sv
// rtl/jtkunio_romrq.sv - cached ROM responder between a graphics layer and its SDRAM slot
module jtkunio_romrq
  import jtkunio_romrq_pkg::*;
#(
  parameter int                AW     = 17,
  parameter int                SDRAMW = DEFAULT_SDRAMW,
  parameter logic [SDRAMW-1:0] OFFSET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_cs,
  input  logic [AW-1:0]     rom_addr,
  output logic [31:0]       rom_data,
  output logic              rom_ok,
  output logic [SDRAMW-1:0] sdram_addr,
  output logic              sdram_req,
  input  logic              sdram_ack,
  input  logic              data_dst,
  input  logic              data_rdy,
  input  logic [31:0]       din
);

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     req_addr_q, req_addr_d;
  logic [SDRAMW-1:0] sdram_addr_q, sdram_addr_d;
  logic              sdram_req_q, sdram_req_d;
  logic              rom_ok_q, rom_ok_d;
  logic [31:0]       rom_data_q, rom_data_d;
  logic              hit;
  logic [31:0]       hit_data;
  logic              fill_en;

  jtkunio_romrq_tags #(
    .AW(AW)
  ) u_tags (
    .clk        (clk),
    .rst        (rst),
    .lookup_en  (rom_cs),
    .lookup_addr(rom_addr),
    .hit        (hit),
    .hit_data   (hit_data),
    .fill_en    (fill_en),
    .fill_tag   (req_addr_q),
    .fill_data  (din)
  );

  // Output staging and the single-outstanding fetch sequencer
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    sdram_addr_d = sdram_addr_q;
    sdram_req_d  = sdram_req_q;
    fill_en      = 1'b0;
    rom_ok_d     = rom_cs && hit;
    rom_data_d   = (rom_cs && hit) ? hit_data : rom_data_q;
    case (state_q)
      ST_IDLE: begin
        if (rom_cs && !hit) begin
          req_addr_d   = rom_addr;
          sdram_addr_d = OFFSET + SDRAMW'(rom_addr);
          sdram_req_d  = 1'b1;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          sdram_req_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (data_dst && data_rdy) begin
          fill_en = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and fetch state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_addr_q   <= '0;
      sdram_addr_q <= '0;
      sdram_req_q  <= 1'b0;
      rom_ok_q     <= 1'b0;
      rom_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      sdram_addr_q <= sdram_addr_d;
      sdram_req_q  <= sdram_req_d;
      rom_ok_q     <= rom_ok_d;
      rom_data_q   <= rom_data_d;
    end
  end

  assign rom_ok     = rom_ok_q;
  assign rom_data   = rom_data_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;

endmodule
